// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - ALU with multi-cycle multiply/divide unit and HI/LO registers.
// Define ALU_MDU_DIV_EN to build the divider; without it div/divu are inert.
module alu_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       aluOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             start,
    output logic [WIDTH-1:0] out,
    output logic             logicOutput,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q;
    logic             op_div_q, op_signed_q;
    logic             launchable, launch, finish;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, result;
    logic [WIDTH-1:0] div_q, div_r;

    always_comb begin
        launchable = (aluOp == 6'd8) || (aluOp == 6'd9);
`ifdef ALU_MDU_DIV_EN
        launchable = launchable || (aluOp == 6'd10) || (aluOp == 6'd11);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Counter is loaded with latency-1 so completion lands on the latency-th edge after launch.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && launchable) begin
                    launch     = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_div_q    <= 1'b0;
            op_signed_q <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            if (launch) begin
                a_q         <= A;
                b_q         <= B;
                op_div_q    <= aluOp[1];
                op_signed_q <= ~aluOp[0];
                cnt         <= aluOp[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            end else if (busy && !finish) begin
                cnt <= cnt - CW'(1);
            end

            if (finish) begin
                hi <= result[2*WIDTH-1:WIDTH];
                lo <= result[WIDTH-1:0];
            end else if (!busy && aluOp == 6'd12) begin
                hi <= A;
            end else if (!busy && aluOp == 6'd13) begin
                lo <= A;
            end
        end
    end

    always_comb begin
        ext_a   = {{WIDTH{op_signed_q & a_q[WIDTH-1]}}, a_q};
        ext_b   = {{WIDTH{op_signed_q & b_q[WIDTH-1]}}, b_q};
        product = ext_a * ext_b;
    end

`ifdef ALU_MDU_DIV_EN
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, b_safe, quot_mag, rem_mag;

    // Sign-magnitude division; most-negative / -1 wraps naturally to lo=most-negative, hi=0.
    always_comb begin
        a_neg    = op_signed_q & a_q[WIDTH-1];
        b_neg    = op_signed_q & b_q[WIDTH-1];
        a_mag    = a_neg ? -a_q : a_q;
        b_mag    = b_neg ? -b_q : b_q;
        b_safe   = (b_q == '0) ? WIDTH'(1) : b_mag;
        quot_mag = a_mag / b_safe;
        rem_mag  = a_mag % b_safe;
        if (b_q == '0) begin
            div_q = '1;
            div_r = a_q;
        end else begin
            div_q = (a_neg ^ b_neg) ? -quot_mag : quot_mag;
            div_r = a_neg ? -rem_mag : rem_mag;
        end
    end
`else
    assign div_q = '0;
    assign div_r = '0;
`endif

    assign result = op_div_q ? {div_r, div_q} : product;

    always_comb begin
        out         = '0;
        logicOutput = 1'b0;
        case (aluOp)
            6'd0:  out = A + B;
            6'd1:  out = A - B;
            6'd2:  out = A | B;
            6'd3:  out = {B[WIDTH/2-1:0], A[WIDTH/2-1:0]};
            6'd4:  logicOutput = (A == B);
            6'd5:  out = A & B;
            6'd6:  out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            6'd7:  out = {{(WIDTH-1){1'b0}}, (A < B)};
            6'd14: out = hi;
            6'd15: out = lo;
            default: out = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - randomized self-checking bench for alu_mdu against a behavioural model.
module tb_alu_mdu;

`ifdef ALU_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset, start, logicOutput, busy;
    logic [5:0]  aluOp;
    logic [31:0] A, B, out, hi, lo;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: result computed once at launch, delivered after the latency.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          m_busy;
    int          m_left;

    alu_mdu #(.WIDTH(32), .MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .aluOp(aluOp), .A(A), .B(B), .start(start),
        .out(out), .logicOutput(logicOutput), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_out(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            6'd0:  return a + b;
            6'd1:  return a - b;
            6'd2:  return a | b;
            6'd3:  return {b[15:0], a[15:0]};
            6'd5:  return a & b;
            6'd6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'd7:  return (a < b) ? 32'd1 : 32'd0;
            6'd14: return m_hi;
            6'd15: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_launch(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        logic [63:0] up;
        int sa, sb;
        sa = a;
        sb = b;
        if (op == 6'd8) begin
            sp = longint'(sa) * longint'(sb);
            {p_hi, p_lo} = sp;
        end else if (op == 6'd9) begin
            up = {32'd0, a} * {32'd0, b};
            {p_hi, p_lo} = up;
        end else if (b == 32'd0) begin
            p_lo = 32'hFFFF_FFFF;
            p_hi = a;
        end else if (op == 6'd10) begin
            if (a == 32'h8000_0000 && sb == -1) begin
                p_lo = 32'h8000_0000;
                p_hi = 32'd0;
            end else begin
                p_lo = sa / sb;
                p_hi = sa % sb;
            end
        end else begin
            p_lo = a / b;
            p_hi = a % b;
        end
        m_busy = 1'b1;
        m_left = (op >= 6'd10) ? DIV_LAT : MULT_LAT;
    endtask

    task automatic model_edge(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic st, input logic rs);
        if (rs) begin
            m_hi = 0; m_lo = 0; m_busy = 0; m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (st && (op == 6'd8 || op == 6'd9 || (DIV_EN && (op == 6'd10 || op == 6'd11)))) begin
            model_launch(op, a, b);
        end else if (op == 6'd12) begin
            m_hi = a;
        end else if (op == 6'd13) begin
            m_lo = a;
        end
    endtask

    // One clock: combinational check before the edge, registered check 1ns after it.
    task automatic cycle(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic st, input logic rs);
        aluOp = op; A = a; B = b; start = st; reset = rs;
        #1;
        check("out", {32'd0, out}, {32'd0, model_out(op, a, b)});
        check("logicOutput", {63'd0, logicOutput}, {63'd0, (op == 6'd4) && (a == b)});
        @(posedge clk);
        model_edge(op, a, b, st, rs);
        #1;
        check("busy", {63'd0, busy}, {63'd0, m_busy});
        check("hi", {32'd0, hi}, {32'd0, m_hi});
        check("lo", {32'd0, lo}, {32'd0, m_lo});
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] op;
        aluOp = 0; A = 0; B = 0; start = 0; reset = 1;
        @(posedge clk);
        model_edge(0, 0, 0, 0, 1);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);

        cycle(6'd0, 32'hFFFF_FFFF, 32'd1, 0, 0);
        check("addu_wrap", {32'd0, out}, 64'd0);
        cycle(6'd6, 32'hFFFF_FFFF, 32'd1, 0, 0);
        check("slt_neg", {32'd0, out}, 64'd1);
        cycle(6'd7, 32'hFFFF_FFFF, 32'd1, 0, 0);
        check("sltu_big", {32'd0, out}, 64'd0);
        cycle(6'd4, 32'd5, 32'd5, 0, 0);
        check("equ_flag", {63'd0, logicOutput}, 64'd1);

        cycle(6'd8, 32'hFFFF_FFFE, 32'd3, 1, 0);
        for (int i = 0; i < MULT_LAT; i++) cycle(6'd0, $urandom, $urandom, 0, 0);
        check("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("mult_lo", {32'd0, lo}, 64'hFFFF_FFFA);
        cycle(6'd9, 32'hFFFF_FFFE, 32'd3, 1, 0);
        for (int i = 0; i < MULT_LAT; i++) cycle(6'd15, 32'd0, 32'd0, 0, 0);
        check("multu_hi", {32'd0, hi}, 64'h2);
        check("multu_lo", {32'd0, lo}, 64'hFFFF_FFFA);

        cycle(6'd10, 32'hFFFF_FFF9, 32'd2, 1, 0);
        for (int i = 0; i < DIV_LAT; i++) cycle(6'd14, 32'd0, 32'd0, 0, 0);
        check("div_lo", {32'd0, lo}, DIV_EN ? 64'hFFFF_FFFD : 64'hFFFF_FFFA);
        cycle(6'd11, 32'd7, 32'd0, 1, 0);
        for (int i = 0; i < DIV_LAT; i++) cycle(6'd14, 32'd0, 32'd0, 0, 0);
        check("divu0_lo", {32'd0, lo}, DIV_EN ? 64'hFFFF_FFFF : 64'hFFFF_FFFA);

        // Start and mthi during an in-flight mult must be ignored.
        cycle(6'd8, 32'd1000, 32'd7, 1, 0);
        cycle(6'd0, 32'd0, 32'd0, 0, 0);
        cycle(6'd10, 32'd50, 32'd3, 1, 0);
        cycle(6'd12, 32'h1234, 32'd0, 1, 0);
        cycle(6'd13, 32'h5678, 32'd0, 0, 0);
        cycle(6'd0, 32'd0, 32'd0, 0, 0);
        check("mult_guard_hi", {32'd0, hi}, 64'd0);
        check("mult_guard_lo", {32'd0, lo}, 64'd7000);

        // Reset aborts an in-flight divide.
        cycle(6'd11, 32'd100, 32'd9, 1, 0);
        for (int i = 0; i < 3; i++) cycle(6'd0, 32'd0, 32'd0, 0, 0);
        cycle(6'd0, 32'd0, 32'd0, 0, 1);
        for (int i = 0; i < DIV_LAT; i++) cycle(6'd0, 32'd0, 32'd0, 0, 0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        cycle(6'd13, 32'hABCD, 32'd0, 0, 0);
        cycle(6'd15, 32'd0, 32'd0, 0, 0);
        check("mflo_after_mtlo", {32'd0, out}, 64'hABCD);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    op = 6'($urandom_range(8, 11));
                2:       op = 6'($urandom_range(12, 15));
                3:       op = 6'($urandom_range(16, 63));
                default: op = 6'($urandom_range(0, 15));
            endcase
            cycle(op, rand_operand(), rand_operand(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 60) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (even, >= 16).
REQ-002 SHALL have parameter MULT_CYCLES, default 5, multiply latency in clock cycles (>= 1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, divide latency in clock cycles (>= 1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 aluOp  input  6  operation select.
REQ-007 A  input  WIDTH  operand A (rs).
REQ-008 B  input  WIDTH  operand B (rt/imm).
REQ-009 start  input  1  launches the mult/div selected by aluOp.
REQ-010 out  output  WIDTH  combinational result.
REQ-011 logicOutput  output  1  combinational compare flag.
REQ-012 busy  output  1  registered; high while a mult/div is in flight.
REQ-013 hi, lo  output  WIDTH each  registered HI/LO contents.

Function
REQ-014 Combinational ops, out/logicOutput same cycle: 0 addu A+B; 1 subu A-B; 2 or A|B; 3 lui {B[WIDTH/2-1:0],A[WIDTH/2-1:0]}; 4 equ logicOutput=(A==B), out=0; 5 and A&B; 6 slt signed A<B -> out=1 else 0; 7 sltu unsigned A<B -> 1 else 0.
REQ-015 logicOutput SHALL be 0 for every op except equ; arithmetic SHALL wrap modulo 2^WIDTH, no overflow flag.
REQ-016 Ops 8 mult, 9 multu, 10 div, 11 divu SHALL launch only at a rising edge with start=1 and busy=0; out=0 for these ops.
REQ-017 Launch edge SHALL latch A, B, op; busy=1 from that edge; busy=0 and hi/lo written at the MULT_CYCLES-th (mult) or DIV_CYCLES-th (div) following edge.
REQ-018 mult/multu: {hi,lo} = 2*WIDTH-bit signed/unsigned product.
REQ-019 div/divu: lo = quotient, hi = remainder; signed div truncates toward zero, remainder takes dividend sign.
REQ-020 Divide by zero: lo = all ones, hi = latched A; same latency, no error flag.
REQ-021 Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
REQ-022 start=1 while busy=1 SHALL be ignored; the in-flight op SHALL complete unchanged.
REQ-023 start=1 with a non-mult/div aluOp SHALL be ignored.
REQ-024 Op 12 mthi: hi<=A at edge; op 13 mtlo: lo<=A at edge; both ignored while busy=1; do not require start.
REQ-025 Op 14 mfhi: out=hi; op 15 mflo: out=lo; while busy=1 they return the pre-operation values (caller stalls on busy).
REQ-026 Unlisted aluOp codes: out=0, logicOutput=0, no state change.
REQ-027 Operands changing after the launch edge SHALL NOT affect the result.
REQ-028 busy SHALL fall and a new launch MAY be accepted at that same edge only if start is sampled after busy=0, i.e. earliest relaunch is the edge following completion.

Reset
REQ-029 reset=1 at a rising edge SHALL set hi=0, lo=0, busy=0, clear latched operands and cycle counter.
REQ-030 Reset during an in-flight op SHALL abort it; no hi/lo write occurs; reset has priority over start, mthi, mtlo.
REQ-031 Combinational outputs SHALL follow inputs during reset (mfhi/mflo return 0 after the reset edge).

Configuration
REQ-032 Macro ALU_MDU_DIV_EN defined: div/divu implemented per REQ-019..021.
REQ-033 ALU_MDU_DIV_EN undefined: no divider logic; div/divu never launch, busy stays 0, hi/lo unchanged, out=0; mult/multu and all other ops unaffected.

Verification
REQ-034 addu A=0xFFFFFFFF,B=1 -> out=0; slt A=0xFFFFFFFF,B=1 -> out=1; sltu same -> out=0; equ A=B=5 -> logicOutput=1.
REQ-035 mult A=0xFFFFFFFE(-2),B=3, start one cycle -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same -> hi=0x2, lo=0xFFFFFFFA.
REQ-036 div A=-7,B=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu A=7,B=0 -> lo=0xFFFFFFFF, hi=7.
REQ-037 mult in flight, cycle 2: start with div, mthi A=0x1234 -> ignored; final hi/lo equal mult result only.
REQ-038 div in flight, reset pulsed at cycle 4 -> next edge busy=0, hi=lo=0, no later write; then mtlo A=0xABCD -> mflo out=0xABCD.
REQ-039 Build without ALU_MDU_DIV_EN: div start -> busy stays 0, hi/lo unchanged; mult still per REQ-035.
